seq_addsub: RTL
===============

Name: seq_addsub

Overview:
- Multi-cycle, parametrised-width ripple adder/subtractor.
- Each cycle it processes one CHUNK-bit slice of the operands, least-significant slice first.
- A registered carry links each slice to the next; a start/busy/done handshake frames each operation.
- Sits behind pushbutton/UART operand capture and feeds seven-segment and LED display logic. It replaces the fixed 4-bit combinational adder with a width-scalable, area-bounded unit.

Parameters:
- WIDTH, 16, operand and result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH.
- Derived: NCHUNK = WIDTH/CHUNK, the number of slice cycles per operation.

Ports:
- hz100  input  1  clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a new operation; sampled on rising edge
- sub  input  1  0 = add, 1 = subtract; sampled with start
- cin  input  1  carry-in for add mode; ignored in subtract mode
- a  input  WIDTH  operand A (unsigned or two's complement)
- b  input  WIDTH  operand B
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: result outputs just updated
- sum  output  WIDTH  result, held until the next completion
- cout  output  1  carry out of MSB; in subtract mode 1 = no borrow
- ovf  output  1  signed two's-complement overflow
- zero  output  1  sum == 0

Behaviour:
- Reset: asynchronous and active-high.
  - State goes to IDLE immediately.
  - busy, done, sum, cout, ovf and zero all go to 0.
  - Internal operand, carry and slice-counter registers are cleared.
- States: IDLE, RUN, DONE.
- IDLE / DONE with start=1 at an edge:
  - Latch A=a.
  - Latch B = sub ? ~b : b.
  - Latch carry = sub ? 1 : cin.
  - Slice index = 0; go to RUN; busy=1 from that edge.
- RUN, one slice per edge, at slice index k:
  - S_k = A[k] + B[k] + carry, computed over CHUNK bits.
  - Store the low CHUNK bits into result slice k; carry = bit CHUNK of the slice sum.
  - When k = NCHUNK-1, go to DONE on the same edge. Otherwise k = k+1.
- Result update on the edge that finishes the last slice:
  - sum = assembled result.
  - cout = final carry.
  - ovf = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]), using the latched, post-inversion B.
  - zero = (sum == 0).
  - busy goes to 0.
- DONE:
  - done=1 for exactly one cycle.
  - If start=1 on that edge, a new operation is accepted (back-to-back, no idle gap). Otherwise go to IDLE.
  - done deasserts on the next edge in either case.
- Latency: start sampled at edge E0, done high during the cycle after edge E_NCHUNK. Throughput: one operation per NCHUNK+1 cycles maximum.
- Output stability: sum, cout, ovf and zero keep the previous result throughout RUN; no partial results are visible.
- start while busy (RUN): ignored; no effect on the operation in flight.
- Operand changes during RUN: no effect; operands are latched.
- sub/cin changes during RUN: no effect.
- Reset mid-RUN: abort immediately and apply the reset values above; the next start begins a clean operation.
- CHUNK = WIDTH: NCHUNK = 1; the block degenerates to a one-cycle registered adder with the same handshake.
- CHUNK = 1: pure bit-serial operation, WIDTH cycles.
- All arithmetic is modulo 2^WIDTH; the carry register is 1 bit.

Test Plan:
- Add (WIDTH=16, CHUNK=4): a=0x1234, b=0x4321, sub=0, cin=0, start 1 cycle.
  - busy for 4 cycles, then done pulse.
  - sum=0x5555, cout=0, ovf=0, zero=0.
- Carry through all slices: a=0xFFFF, b=0x0001, cin=0.
  - sum=0x0000, cout=1, zero=1, ovf=0.
  - Repeat with a=0xFFFF, b=0x0000, cin=1: same result.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=1 (ignored).
  - sum=0xFFFE, cout=0 (borrow), ovf=0.
  - Then a=0x8000, b=0x0001, sub=1: sum=0x7FFF, cout=1, ovf=1.
- Signed overflow: a=0x7FFF, b=0x0001, add.
  - sum=0x8000, ovf=1, cout=0.
  - During RUN, sum still shows the previous result (0x7FFF).
- Protocol:
  - Start pulses in RUN with a=0xAAAA: ignored; the first result is unchanged.
  - start held high through the DONE cycle: second op accepted, done pulses once per op.
  - reset asserted mid-RUN (second slice): busy/done/sum/flags go to 0 asynchronously; a following a=1, b=2 add yields sum=3.
- Parameter sweep: (WIDTH, CHUNK) = (8,8), (8,1), (32,4), (12,3).
  - Random add/sub vectors checked against a reference model.
  - done latency = NCHUNK cycles after the start edge.

Source files
------------

// File: rtl/seq_addsub.sv
// Multi-cycle ripple adder/subtractor: one CHUNK-bit slice per clock, LSB slice first,
// with a registered carry between slices and a start/busy/done handshake.
module seq_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             hz100,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
    logic [WIDTH-1:0] b_sel;
    logic [CHUNK:0]   slice_sum;

    // Operands shift right each slice so the active slice always sits in the low bits;
    // the MSBs needed for overflow are captured separately at start.
    assign slice_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    assign b_sel     = sub ? ~b : b;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_d     = a;
                    b_d     = b_sel;
                    carry_d = sub | cin;
                    idx_d   = '0;
                    res_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b_sel[WIDTH-1];
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = slice_sum[CHUNK];
                // New slice enters at the top; after NCHUNK slices slice 0 lands at bit 0.
                res_d   = (res_q >> CHUNK) | (WIDTH'(slice_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                    sum_d   = res_d;
                    cout_d  = slice_sum[CHUNK];
                    ovf_d   = (a_msb_q == b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
                    zero_d  = (res_d == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;
endmodule
